msx_rom_mapper_sync: RTL
========================

// Module: msx_rom_mapper_sync
// PURPOSE
//  Clocked, parametrised MegaROM mapper for the MSX cartridge slot. It synchronises the Z80 bus
//  strobes and detects bank-switch writes, one per bus cycle. It holds four 8kB page registers and
//  drives the upper flash address lines. Runtime mode selects Konami-SCC, Konami, ASCII8 or ASCII16.
// PARAMETERS
//  SEG_W        6   segment register width; flash upper address = SEG_W bits (6 -> 512kB), 1..8
//  SYNC_STAGES  2   flip-flop stages on wr_n/rd_n/sltsl_n, >=2
// PORTS
//  clk           in   1      system clock; all state on rising edge
//  reset         in   1      synchronous, active-high reset
//  mode          in   2      0=Konami-SCC 1=Konami 2=ASCII8 3=ASCII16
//  addr_hi       in   5      bus A15..A11
//  data          in   8      bus D7..D0; low SEG_W bits stored
//  sltsl_n       in   1      slot select, active low, async to clk
//  wr_n, rd_n    in   1      bus strobes, active low, async to clk
//  out_addr      out  SEG_W  flash upper address (combinational from regs + addr_hi)
//  bank_wr       out  1      one-clk pulse when a page register is written
//  bank_idx      out  2      page index written, valid with bank_wr
// BEHAVIOUR
//  - Reset: regs r0..r3 = 0,1,2,3; FSM=IDLE; bank_wr=0; bank_idx=0; sync chains=1 (inactive).
//  - Page index p = {~A14, A13}: 4000/C000->0, 6000/E000->1, 8000/0000->2, A000/2000->3.
//  - out_addr: Konami-SCC/Konami/ASCII8 = r[p]. ASCII16 = {r[{p[1],1'b0}][SEG_W-2:0], A13}.
//  - wr_s/sl_s = synchronised wr_n/sltsl_n. addr_hi/data are sampled raw in IDLE only.
//  - Bus is stable by then (>=SYNC_STAGES clk after strobe).
//  - FSM IDLE: wr_s=0 & sl_s=0 -> decode. On a hit: write reg, bank_wr=1 for one clk, go WAIT_REL.
//    On a miss: go WAIT_REL with no pulse.
//  - WAIT_REL: stay while wr_s=0; wr_s=1 or sl_s=1 -> IDLE. Exactly one decode per write cycle.
//  - Decode by mode (A15..A11; mirrors inside the 2kB window):
//     Konami-SCC: 5000->r0, 7000->r1, 9000->r2, B000->r3.
//     Konami:     r0 fixed 0, writes ignored; 6000->r1, 8000->r2, A000->r3.
//     ASCII8:     6000->r0, 6800->r1, 7000->r2, 7800->r3.
//     ASCII16:    6000->r0, 7000->r2; r1/r3 unused.
//  - Stored value = data[SEG_W-1:0]; higher data bits are ignored (no wrap error).
//  - rd_n is synchronised and sampled only for ordering. If wr_s and rd_s are both low, treat the cycle as a write.
//  - Mode change takes effect next clk for decode and out_addr; registers are not cleared.
//    The Konami r0 is forced 0 on out_addr only.
//  - Reset in WAIT_REL: return to IDLE with regs re-initialised. Bus write held across reset release is
//    decoded once (reset sync chains to 1 guarantees detection).
//  - sltsl_n deasserted mid-write: WAIT_REL exits; no second decode.
// CONFIGURATION
//  SCC_SEL_EN defined: adds output scc_sel (1). In Konami-SCC mode, scc_sel =
//    (r2[5:0]==6'h3F) & A15..A11 in 9800-9FFF (combinational); else 0. Writes to 9800-9FFF never
//    touch r2.
//  SCC_SEL_EN undefined: port absent, no SCC decode logic.
// TESTING
//  1 reset, mode=0, read A=4000/6000/8000/A000 -> out_addr 0,1,2,3; bank_wr stays 0
//  2 mode=0, write 5000<-0x2A, strobe held 10 clk -> one bank_wr pulse, bank_idx=0;
//    read C000 -> out_addr 0x2A
//  3 mode=2, writes 6000..7800 <- 4,5,6,7 -> four pulses bank_idx 0..3; write 5000 -> no pulse, regs
//    unchanged
//  4 mode=3, write 7000<-0x05 -> A=8000 gives 0x0A, A=A000 gives 0x0B
//  5 mode=1, write 4000<-0x11 -> no pulse, out_addr@4000=0; write 0xFF to A000 -> r3=0x3F (truncation)
//  6 reset asserted during WAIT_REL, wr_n low through release -> regs 0..3 then one decode of held
//    write; SCC_SEL_EN: r2=0x3F, A=9800 -> scc_sel=1

Source files
------------

// File: rtl/msx_rom_mapper_sync.sv
// msx_rom_mapper_sync: MSX MegaROM mapper (Konami-SCC/Konami/ASCII8/ASCII16) with synchronised bus strobes.
// Define SCC_SEL_EN to add the scc_sel output decoding the SCC register window.
module msx_rom_mapper_sync #(
   parameter int SEG_W       = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [4:0]       addr_hi,
   input  logic [7:0]       data,
   input  logic             sltsl_n,
   input  logic             wr_n,
   input  logic             rd_n,
   output logic [SEG_W-1:0] out_addr,
   output logic             bank_wr,
   output logic [1:0]       bank_idx
`ifdef SCC_SEL_EN
   ,
   output logic             scc_sel
`endif
);
   typedef enum logic {IDLE, WAIT_REL} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] wr_q, rd_q, sl_q;
   logic [SEG_W-1:0] r [4];
   logic wr_s, rd_s, sl_s, wr_act, hit, fire;
   logic [1:0] idx, p;
   assign wr_s = wr_q[SYNC_STAGES-1];
   assign rd_s = rd_q[SYNC_STAGES-1];
   assign sl_s = sl_q[SYNC_STAGES-1];
   // a concurrent read strobe never masks a write
   assign wr_act = ~wr_s | (~wr_s & ~rd_s);
   assign p = {~addr_hi[3], addr_hi[2]};
   always_comb begin
      hit = 1'b0;
      idx = p;
      unique case (mode)
         2'd0: hit = addr_hi inside {5'h0A, 5'h0E, 5'h12, 5'h16};
         2'd1: hit = addr_hi inside {5'h0C, 5'h10, 5'h14};
         2'd2: begin
            hit = addr_hi[4:2] == 3'b011;
            idx = addr_hi[1:0];
         end
         default: begin
            hit = addr_hi inside {5'h0C, 5'h0E};
            idx = {addr_hi[1], 1'b0};
         end
      endcase
   end
   always_comb begin
      state_nx = state;
      fire = 1'b0;
      if (state == IDLE) begin
         state_nx = (wr_act & ~sl_s) ? WAIT_REL : IDLE;
         fire = wr_act & ~sl_s & hit;
      end else begin
         state_nx = (~wr_act | sl_s) ? IDLE : WAIT_REL;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wr_q <= '1;
         rd_q <= '1;
         sl_q <= '1;
         bank_wr <= 1'b0;
         bank_idx <= 2'd0;
         for (int i = 0; i < 4; i++) r[i] <= SEG_W'(i);
      end else begin
         state <= state_nx;
         wr_q <= {wr_q[SYNC_STAGES-2:0], wr_n};
         rd_q <= {rd_q[SYNC_STAGES-2:0], rd_n};
         sl_q <= {sl_q[SYNC_STAGES-2:0], sltsl_n};
         bank_wr <= fire;
         if (fire) begin
            r[idx] <= SEG_W'(data);
            bank_idx <= idx;
         end
      end
   end
   // ASCII16 pairs the 8kB pages into 16kB banks with A13 as the low address bit
   assign out_addr = (mode == 2'd3) ? SEG_W'({r[{p[1], 1'b0}], addr_hi[2]}) :
                     (mode == 2'd1 && p == 2'd0) ? '0 : r[p];
`ifdef SCC_SEL_EN
   assign scc_sel = (mode == 2'd0) && (6'(r[2]) == 6'h3F) && (addr_hi == 5'h13);
`endif
endmodule
